xc_malu_issue: RTL and testbench
================================

Name: xc_malu_issue

Overview:
Request-side sequencer for xc_malu. It accepts one operation per valid/ready handshake from the execute stage and latches the operands. It drives the one-hot uop and pack-width lines into xc_malu, holds them stable until malu_ready, and pulses flush. It then returns the 64-bit result downstream, with backpressure, pipeline abort and a watchdog timeout.

Parameters:
TIMEOUT, 64, max cycles malu_valid may stay high without malu_ready before forced error completion
CW, 7, watchdog counter width; must satisfy 2^CW > TIMEOUT

Ports:
clock  in  1  system clock
resetn  in  1  reset, asynchronous, active-low
abort  in  1  pipeline kill; discards in-flight op
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  4  0 div,1 divu,2 rem,3 remu,4 mul,5 mulu,6 mulsu,7 clmul,8 pmul,9 pclmul,10 madd,11 msub,12 macc,13 mmul
req_pw  in  3  0=32,1=16,2=8,3=4,4=2 bit elements
req_rs1/req_rs2/req_rs3  in  32 each  operands
malu_rs1/malu_rs2/malu_rs3  out  32 each  latched operands
malu_valid  out  1  request to xc_malu
malu_uop  out  14  one-hot uop, bit index = req_op
malu_pw  out  5  one-hot {pw_2,pw_4,pw_8,pw_16,pw_32}
malu_flush  out  1  flush to xc_malu
malu_result  in  64  xc_malu result
malu_ready  in  1  xc_malu result valid
rsp_valid  out  1  response valid
rsp_ready  in  1  response accepted
rsp_result  out  64  captured result
rsp_err  out  1  illegal request or timeout

Behaviour:
- Reset, asynchronous:
  - state=IDLE.
  - All outputs 0, except req_ready=1.
  - Operand, uop and pw registers are 0.
- States:
  - IDLE: req_ready=1.
  - BUSY: malu_valid=1, req_ready=0.
  - RESP: rsp_valid=1.
- Legality:
  - req_op<=13 is required.
  - For ops 8 and 9, req_pw must be 0..4.
  - For all other ops, req_pw must be 0.
  - Anything else is illegal.
- IDLE, legal accept:
  - Latch operands, uop (one-hot of req_op) and pw (one-hot of req_pw).
  - Clear watchdog; go BUSY.
  - malu_valid rises the cycle after the accept.
- IDLE, illegal accept:
  - No xc_malu request.
  - Go RESP with rsp_err=1, rsp_result=0.
- BUSY:
  - malu_rs*, malu_uop and malu_pw are held constant.
  - Watchdog increments each cycle.
  - malu_flush = malu_valid && malu_ready, combinational, same cycle.
  - On malu_ready: capture malu_result into rsp_result, rsp_err=0, go RESP.
  - Watchdog reaching TIMEOUT without malu_ready: malu_flush=1 for that cycle; rsp_result=0, rsp_err=1; go RESP.
- RESP:
  - rsp_valid=1; rsp_result and rsp_err held until rsp_ready.
  - req_ready = rsp_ready. On rsp_ready && req_valid the next request is accepted in the same cycle (zero-bubble back-to-back).
  - On rsp_ready without req_valid, go IDLE.
- Latency: request accepted at cycle T, malu_ready at cycle T+k (k>=1) -> rsp_valid at cycle T+k+1.
- abort, highest priority:
  - In BUSY: malu_flush=1 this cycle, go IDLE, no response; malu_valid=0 next cycle.
  - In RESP: drop the response, go IDLE.
  - In IDLE: req_ready is forced 0 that cycle; nothing is accepted.
  - abort and malu_ready in the same cycle: abort wins and the result is discarded.
- Invariants:
  - malu_uop and malu_pw are exactly one-hot whenever malu_valid=1.
  - malu_valid never drops without malu_flush being high in the same cycle.
  - malu_valid and rsp_valid are never both 1.
  - Watchdog saturates and does not wrap.

Test Plan:
- mul rs1=FFFFFFFD, rs2=00000005; xc_malu model ready after 3 cycles -> malu_uop=0x0010, malu_pw=0x01, flush pulses once; rsp_result=FFFFFFFFFFFFFFF1, rsp_err=0, rsp_valid 4 cycles after accept.
- pmul req_pw=2, then clmul req_pw=1 -> first: malu_pw=0x04, normal response; second: no malu_valid, rsp_err=1, rsp_result=0 one cycle after accept.
- divu rs1=64, rs2=0, result FFFFFFFF, with rsp_ready low for 5 cycles -> rsp_result=00000000FFFFFFFF held stable throughout; rsp_valid held for 5 cycles with rsp_result unchanged.
- Back-to-back: req_valid held high, op macc rs1=1, rs2=2, rs3=3 then op madd -> second request accepted the same cycle the first response is consumed; rsp results are 0000000100000005 and then the madd value.
- malu_ready never asserted (TIMEOUT=64) -> malu_flush at the 64th BUSY cycle; rsp_err=1, rsp_result=0; malu_valid low next cycle.
- abort in BUSY cycle 2, and abort coincident with malu_ready -> no rsp_valid in either case; malu_flush=1 in the abort cycle; req_ready=1 the following cycle.

Source files
------------

// File: rtl/xc_malu_issue.sv
// Request-side sequencer for xc_malu: accepts one op per handshake, drives the
// one-hot uop/pw lines until xc_malu answers, then returns the result downstream.
module xc_malu_issue #(
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        abort,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [2:0]  req_pw,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  logic [31:0] req_rs3,
   output logic [31:0] malu_rs1,
   output logic [31:0] malu_rs2,
   output logic [31:0] malu_rs3,
   output logic        malu_valid,
   output logic [13:0] malu_uop,
   output logic [4:0]  malu_pw,
   output logic        malu_flush,
   input  logic [63:0] malu_result,
   input  logic        malu_ready,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [63:0] rsp_result,
   output logic        rsp_err
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

   state_t        state;
   logic [CW-1:0] wdog;
   logic          legal;
   logic          accept;
   logic          timeout;

   // Only the packed ops take a non-32-bit element width.
   always_comb begin
      legal = 1'b0;
      if (req_op == 4'd8 || req_op == 4'd9) begin
         legal = (req_pw <= 3'd4);
      end else if (req_op <= 4'd13) begin
         legal = (req_pw == 3'd0);
      end
   end

   always_comb begin
      req_ready = 1'b0;
      unique case (state)
         IDLE:    req_ready = !abort;
         RESP:    req_ready = rsp_ready && !abort;
         default: req_ready = 1'b0;
      endcase
   end

   assign accept     = req_valid && req_ready;
   assign timeout    = (state == BUSY) && (wdog == WD_LAST);
   assign malu_flush = malu_valid && (malu_ready || abort || timeout);

   // A new accept can only happen in IDLE or in RESP while the response is taken,
   // so it is handled ahead of the per-state transitions.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         wdog       <= '0;
         malu_rs1   <= '0;
         malu_rs2   <= '0;
         malu_rs3   <= '0;
         malu_uop   <= '0;
         malu_pw    <= '0;
         malu_valid <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
      end else if (accept) begin
         if (legal) begin
            malu_rs1   <= req_rs1;
            malu_rs2   <= req_rs2;
            malu_rs3   <= req_rs3;
            malu_uop   <= 14'd1 << req_op;
            malu_pw    <= 5'd1 << req_pw;
            wdog       <= '0;
            malu_valid <= 1'b1;
            rsp_valid  <= 1'b0;
            state      <= BUSY;
         end else begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
            rsp_valid  <= 1'b1;
            malu_valid <= 1'b0;
            state      <= RESP;
         end
      end else begin
         unique case (state)
            IDLE: begin
               malu_valid <= 1'b0;
               rsp_valid  <= 1'b0;
            end
            BUSY: begin
               if (wdog != WD_MAX) begin
                  wdog <= wdog + 1'b1;
               end
               if (abort) begin
                  malu_valid <= 1'b0;
                  state      <= IDLE;
               end else if (malu_ready) begin
                  rsp_result <= malu_result;
                  rsp_err    <= 1'b0;
                  malu_valid <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end else if (timeout) begin
                  rsp_result <= '0;
                  rsp_err    <= 1'b1;
                  malu_valid <= 1'b0;
                  rsp_valid  <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (abort || rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               malu_valid <= 1'b0;
               rsp_valid  <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_xc_malu_issue.sv
// Randomized scoreboard bench for xc_malu_issue with a behavioural xc_malu model
// and directed scenarios for latency, errors, backpressure, timeout and abort.
module tb_xc_malu_issue;

   localparam int TIMEOUT = 64;

   typedef struct {
      logic [63:0] res;
      logic        err;
   } exp_t;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        abort = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [3:0]  req_op = '0;
   logic [2:0]  req_pw = '0;
   logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
   logic [31:0] malu_rs1, malu_rs2, malu_rs3;
   logic        malu_valid;
   logic [13:0] malu_uop;
   logic [4:0]  malu_pw;
   logic        malu_flush;
   logic [63:0] malu_result = '0;
   logic        malu_ready = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [63:0] rsp_result;
   logic        rsp_err;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   flush_count = 0;
   int   last_flush_cyc = -1;
   int   rsp_count = 0;
   bit   rand_ready = 1'b0;
   exp_t exp_q[$];
   int   lat_q[$];

   xc_malu_issue #(.TIMEOUT(TIMEOUT), .CW(7)) dut (
      .clock(clock), .resetn(resetn), .abort(abort),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
      .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
      .malu_valid(malu_valid), .malu_uop(malu_uop), .malu_pw(malu_pw), .malu_flush(malu_flush),
      .malu_result(malu_result), .malu_ready(malu_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   // Arithmetic meaning of each op; packed and accumulate ops use bench-chosen mixes.
   function automatic logic [63:0] ref_result(int op, int pw, logic [31:0] a, logic [31:0] b, logic [31:0] c);
      longint      sa = longint'(signed'(a));
      longint      sb = longint'(signed'(b));
      logic [63:0] r = '0;
      case (op)
         0:  r = (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'h0, 32'(sa / sb)};
         1:  r = (b == 0) ? 64'h0000_0000_FFFF_FFFF : {32'h0, a / b};
         2:  r = (b == 0) ? {32'h0, a} : {32'h0, 32'(sa % sb)};
         3:  r = (b == 0) ? {32'h0, a} : {32'h0, a % b};
         4:  r = sa * sb;
         5:  r = {32'h0, a} * {32'h0, b};
         6:  r = sa * longint'({32'h0, b});
         7:  for (int i = 0; i < 32; i++) if (b[i]) r = r ^ ({32'h0, a} << i);
         8,
         9:  r = {a ^ c, b + 32'(pw + op)};
         10: r = {32'h0, a} * {32'h0, b} + {32'h0, c};
         11: r = {32'h0, a} * {32'h0, b} - {32'h0, c};
         12: r = {a, a * b + c};
         13: r = {c, a * b};
         default: r = 64'hDEAD_BEEF_DEAD_BEEF;
      endcase
      return r;
   endfunction

   function automatic bit is_legal(int op, int pw);
      if (op > 13) return 1'b0;
      if (op == 8 || op == 9) return pw <= 4;
      return pw == 0;
   endfunction

   function automatic int onehot_idx(logic [13:0] v);
      for (int i = 0; i < 14; i++) if (v[i]) return i;
      return 15;
   endfunction

   task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // xc_malu model: answers after a per-op latency (0 means never).
   int busy_cnt = 0;
   int cur_lat = 0;
   always @(negedge clock) begin
      if (!malu_valid) begin
         busy_cnt   = 0;
         malu_ready = 1'b0;
      end else begin
         busy_cnt++;
         if (busy_cnt == 1) cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
         if (cur_lat != 0 && busy_cnt == cur_lat) begin
            malu_ready  = 1'b1;
            malu_result = ref_result(onehot_idx(malu_uop), onehot_idx({9'h0, malu_pw}),
                                     malu_rs1, malu_rs2, malu_rs3);
         end else begin
            malu_ready = 1'b0;
         end
      end
   end

   always @(negedge clock) if (rand_ready) rsp_ready = ($urandom_range(0, 3) != 0);

   // Monitor: scoreboard pops on each response handshake, plus protocol invariants.
   bit prev_valid = 1'b0, prev_flush = 1'b0, prev_hold = 1'b0;
   initial forever begin
      @(negedge clock);
      #2;
      if (resetn) begin
         if (malu_flush) begin
            flush_count++;
            last_flush_cyc = cyc;
         end
         if (rsp_valid) rsp_count++;
         if (malu_valid || rsp_valid) checkOutput("valid_exclusive", malu_valid && rsp_valid, 0);
         if (malu_valid) begin
            checkOutput("uop_onehot", $onehot(malu_uop), 1);
            checkOutput("pw_onehot", $onehot(malu_pw), 1);
         end
         if (prev_valid && !malu_valid) checkOutput("drop_needs_flush", prev_flush, 1);
         if (prev_hold) checkOutput("rsp_valid_held", rsp_valid, 1);
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL rsp_unexpected actual=%h required=none", rsp_result);
            end else begin
               checkOutput("rsp_result", rsp_result, exp_q[0].res);
               checkOutput("rsp_err", rsp_err, exp_q[0].err);
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
         prev_valid = malu_valid;
         prev_flush = malu_flush;
         prev_hold  = rsp_valid && !rsp_ready && !abort;
      end
   end

   // Called at a falling edge; returns at the falling edge after the accepting clock.
   task automatic applyStimulus(int op, int pw, logic [31:0] a, logic [31:0] b, logic [31:0] c,
                                int lat, bit hold, output int acc, output bit rsp_at,
                                output logic [63:0] res_at);
      exp_t e;
      bit   ok = 1'b0;
      acc    = -1;
      rsp_at = 1'b0;
      res_at = '0;
      req_op  = 4'(op);
      req_pw  = 3'(pw);
      req_rs1 = a;
      req_rs2 = b;
      req_rs3 = c;
      req_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         #1;
         if (req_ready) ok = 1'b1;
         else @(negedge clock);
      end
      if (!ok) begin
         checkOutput("accept_timeout", 0, 1);
         req_valid = 1'b0;
         return;
      end
      acc    = cyc;
      rsp_at = rsp_valid;
      res_at = rsp_result;
      if (!is_legal(op, pw) || lat == 0) begin
         e.res = '0;
         e.err = 1'b1;
      end else begin
         e.res = ref_result(op, pw, a, b, c);
         e.err = 1'b0;
      end
      exp_q.push_back(e);
      if (is_legal(op, pw)) lat_q.push_back(lat);
      @(negedge clock);
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic waitRsp(string name, int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         if (rsp_valid) ok = 1'b1;
         else @(negedge clock);
      end
      if (!ok) checkOutput(name, 0, 1);
   endtask

   initial begin
      #900000;
      $display("[TB] FAIL global_timeout actual=running required=finished");
      $fatal(1, "[TB] simulation did not finish");
   end

   int          acc, acc2, fb, rb;
   bit          rv;
   logic [63:0] ra;
   int          op, pw, lat;

   initial begin
      repeat (3) @(negedge clock);
      checkOutput("reset_req_ready", req_ready, 1);
      checkOutput("reset_malu_valid", malu_valid, 0);
      checkOutput("reset_rsp_valid", rsp_valid, 0);
      checkOutput("reset_flush", malu_flush, 0);
      checkOutput("reset_uop", malu_uop, 0);
      checkOutput("reset_pw", malu_pw, 0);
      checkOutput("reset_rs1", malu_rs1, 0);
      checkOutput("reset_result", rsp_result, 0);
      checkOutput("reset_err", rsp_err, 0);
      resetn    = 1'b1;
      rsp_ready = 1'b1;
      repeat (2) @(negedge clock);

      // signed multiply, xc_malu answers in its third busy cycle
      fb = flush_count;
      applyStimulus(4, 0, 32'hFFFF_FFFD, 32'h5, 32'h0, 3, 0, acc, rv, ra);
      checkOutput("mul_malu_valid", malu_valid, 1);
      checkOutput("mul_uop", malu_uop, 14'h0010);
      checkOutput("mul_pw", malu_pw, 5'h01);
      checkOutput("mul_rs1", malu_rs1, 32'hFFFF_FFFD);
      waitRsp("mul_rsp_wait", 20);
      checkOutput("mul_latency", cyc - acc, 4);
      checkOutput("mul_result", rsp_result, 64'hFFFF_FFFF_FFFF_FFF1);
      checkOutput("mul_err", rsp_err, 0);
      @(negedge clock);
      checkOutput("mul_flush_once", flush_count - fb, 1);

      // packed width accepted, then an illegal width on a non-packed op
      applyStimulus(8, 2, 32'h1234_5678, 32'h9, 32'h0F0F_0F0F, 2, 0, acc, rv, ra);
      checkOutput("pmul_pw", malu_pw, 5'h04);
      waitRsp("pmul_rsp_wait", 20);
      @(negedge clock);
      applyStimulus(7, 1, 32'h3, 32'h5, 32'h0, 2, 0, acc, rv, ra);
      checkOutput("illegal_rsp_valid", rsp_valid, 1);
      checkOutput("illegal_no_malu", malu_valid, 0);
      checkOutput("illegal_err", rsp_err, 1);
      checkOutput("illegal_result", rsp_result, 0);
      @(negedge clock);

      // divide by zero with downstream stalled for five cycles
      rsp_ready = 1'b0;
      applyStimulus(1, 0, 32'd64, 32'd0, 32'd0, 1, 0, acc, rv, ra);
      waitRsp("divu_rsp_wait", 20);
      for (int i = 0; i < 5; i++) begin
         checkOutput("divu_hold_valid", rsp_valid, 1);
         checkOutput("divu_hold_result", rsp_result, 64'h0000_0000_FFFF_FFFF);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      checkOutput("divu_released", rsp_valid, 0);

      // back-to-back: second request taken in the cycle the first response leaves
      applyStimulus(12, 0, 32'd1, 32'd2, 32'd3, 2, 1, acc, rv, ra);
      applyStimulus(10, 0, 32'd7, 32'd9, 32'd4, 2, 0, acc2, rv, ra);
      checkOutput("b2b_zero_bubble", rv, 1);
      checkOutput("b2b_macc_result", ra, 64'h0000_0001_0000_0005);
      waitRsp("b2b_madd_wait", 20);
      checkOutput("b2b_madd_result", rsp_result, 64'd67);
      @(negedge clock);

      // watchdog: xc_malu never answers
      fb = flush_count;
      applyStimulus(5, 0, 32'd3, 32'd4, 32'd0, 0, 0, acc, rv, ra);
      waitRsp("timeout_rsp_wait", 100);
      checkOutput("timeout_latency", cyc - acc, TIMEOUT + 1);
      checkOutput("timeout_flush_cycle", last_flush_cyc - acc, TIMEOUT);
      checkOutput("timeout_flush_once", flush_count - fb, 1);
      checkOutput("timeout_err", rsp_err, 1);
      checkOutput("timeout_result", rsp_result, 0);
      checkOutput("timeout_malu_low", malu_valid, 0);
      @(negedge clock);

      // abort in the second busy cycle, then abort coincident with malu_ready
      for (int k = 0; k < 2; k++) begin
         rb = rsp_count;
         applyStimulus(6, 0, 32'h8000_0001, 32'h7, 32'h0, (k == 0) ? 5 : 2, 0, acc, rv, ra);
         @(negedge clock);
         abort = 1'b1;
         void'(exp_q.pop_back());
         @(negedge clock);
         abort = 1'b0;
         #1;
         checkOutput("abort_req_ready", req_ready, 1);
         checkOutput("abort_malu_low", malu_valid, 0);
         checkOutput("abort_flush_cycle", last_flush_cyc - acc, 2);
         repeat (8) @(negedge clock);
         checkOutput("abort_no_rsp", rsp_count - rb, 0);
      end

      // abort while idle blocks acceptance
      abort     = 1'b1;
      req_op    = 4'd4;
      req_pw    = 3'd0;
      req_valid = 1'b1;
      #1;
      checkOutput("idle_abort_ready", req_ready, 0);
      @(negedge clock);
      abort     = 1'b0;
      req_valid = 1'b0;
      #1;
      checkOutput("idle_abort_no_busy", malu_valid, 0);
      checkOutput("idle_abort_no_rsp", rsp_valid, 0);
      @(negedge clock);

      // random traffic with random downstream backpressure
      rand_ready = 1'b1;
      for (int n = 0; n < 60; n++) begin
         op  = $urandom_range(0, 15);
         pw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) :
               ((op == 8 || op == 9) ? $urandom_range(0, 4) : 0);
         lat = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 6);
         applyStimulus(op, pw, $urandom, $urandom, $urandom, lat, 1'($urandom_range(0, 1)), acc, rv, ra);
      end
      req_valid  = 1'b0;
      rand_ready = 1'b0;
      @(negedge clock);
      rsp_ready = 1'b1;
      for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clock);
      checkOutput("drain_queue_empty", exp_q.size(), 0);
      repeat (2) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
